// File: rtl/bidi_message_queue_stream_port_pkg.sv
// Shared types and helpers for the stream-side message queue port.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: FSM state enum, per-direction queue size, wrapping pointer increment.
package bidi_message_queue_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IN_WR    = 2'd1,
      OUT_RD   = 2'd2,
      OUT_WAIT = 2'd3
   } mq_state_t;

   // Words per direction: half of the SRAM.
   function automatic logic [31:0] queue_sz(input int unsigned addr_bits);
      return 32'd1 << (addr_bits - 1);
   endfunction

   // Queue size is a power of two, so the modulo is a mask.
   function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int unsigned addr_bits);
      return (ptr + 32'd1) & (queue_sz(addr_bits) - 32'd1);
   endfunction

endpackage

// File: rtl/bidi_message_queue_stream_port_if.sv
// Bundle of stream, pointer, SRAM and irq signals for the stream-side queue port.
// Latency: n/a (wiring only).
// Backpressure: inbound/outbound are valid/ready; SRAM port has no stall.
// Modports: master = the stream port block, slave = device/processor/SRAM side.
interface bidi_message_queue_stream_port_if #(
   parameter int QUEUE_ADDR_BITS = 10
);
   logic [31:0]                inbound_data;
   logic                       inbound_valid;
   logic                       inbound_ready;
   logic [31:0]                outbound_data;
   logic                       outbound_valid;
   logic                       outbound_ready;
   logic [31:0]                inbound_rd_ptr;
   logic [31:0]                inbound_wr_ptr;
   logic [31:0]                outbound_wr_ptr;
   logic [31:0]                outbound_rd_ptr;
   logic [QUEUE_ADDR_BITS-1:0] sram_addr;
   logic                       sram_read_en;
   logic                       sram_write_en;
   logic [31:0]                sram_write_data;
   logic [31:0]                sram_read_data;
   logic                       irq;
   logic                       irq_ack;

   modport master (
      input  inbound_data, inbound_valid, outbound_ready,
      input  inbound_rd_ptr, outbound_wr_ptr, sram_read_data, irq_ack,
      output inbound_ready, outbound_data, outbound_valid,
      output inbound_wr_ptr, outbound_rd_ptr,
      output sram_addr, sram_read_en, sram_write_en, sram_write_data, irq
   );

   modport slave (
      output inbound_data, inbound_valid, outbound_ready,
      output inbound_rd_ptr, outbound_wr_ptr, sram_read_data, irq_ack,
      input  inbound_ready, outbound_data, outbound_valid,
      input  inbound_wr_ptr, outbound_rd_ptr,
      input  sram_addr, sram_read_en, sram_write_en, sram_write_data, irq
   );
endinterface

// File: rtl/bidi_message_queue_stream_port_rr_arb.sv
// Two-requester round-robin arbiter; requester 0 = inbound, 1 = outbound.
// Latency: grant is combinational from req; last-grant state updates at the edge.
// Backpressure: none; a grant is assumed to be taken in the cycle it is given.
// Ports: clk, rst (sync, active-high), req[1:0] in, gnt[1:0] out (one-hot or zero).
module bidi_message_queue_rr_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);
   // 1 means requester 1 won most recently; reset value hands the first tie to requester 0.
   logic last_gnt;

   always_comb begin
      gnt = 2'b00;
      if (req[0] && (!req[1] || last_gnt)) begin
         gnt[0] = 1'b1;
      end else if (req[1]) begin
         gnt[1] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_gnt <= 1'b1;
      end else if (gnt[0]) begin
         last_gnt <= 1'b0;
      end else if (gnt[1]) begin
         last_gnt <= 1'b1;
      end
   end
endmodule

// File: rtl/bidi_message_queue_stream_port.sv
// Stream-side end of the bidirectional message queue: inbound stream -> SRAM, SRAM -> outbound stream.
// Latency: inbound handshake N, write N+1, wr_ptr N+2; outbound grant N, read N+1, valid N+3.
// Backpressure: inbound_ready only in IDLE with inbound grant and not full; outbound holds data until ready.
// Ports: clk, rst (sync, active-high), bus (master modport: streams, pointers, SRAM port, irq/irq_ack).
// Option: define BIDI_MESSAGE_QUEUE_STREAM_IRQ_EN to enable the inbound-data interrupt; otherwise irq is 0.
module bidi_message_queue_stream_port #(
   parameter int QUEUE_ADDR_BITS = 10
) (
   input  logic                            clk,
   input  logic                            rst,
   bidi_message_queue_stream_port_if.master bus
);
   import bidi_message_queue_pkg::*;

   localparam int PW = QUEUE_ADDR_BITS - 1;   // significant pointer bits

   mq_state_t                  state;
   logic [31:0]                in_wr_ptr;
   logic [31:0]                out_rd_ptr;
   logic [31:0]                in_wr_ptr_nxt;
   logic [31:0]                out_rd_ptr_nxt;
   logic [31:0]                out_data;
   logic                       out_valid;
   logic [QUEUE_ADDR_BITS-1:0] addr_q;
   logic                       rd_en_q;
   logic                       wr_en_q;
   logic [31:0]                wdata_q;
   logic                       in_full;
   logic                       out_avail;
   logic [1:0]                 req;
   logic [1:0]                 gnt;

   assign in_wr_ptr_nxt  = ptr_inc(in_wr_ptr, QUEUE_ADDR_BITS);
   assign out_rd_ptr_nxt = ptr_inc(out_rd_ptr, QUEUE_ADDR_BITS);

   // One slot stays empty so that full and empty are distinguishable.
   assign in_full   = (in_wr_ptr_nxt[PW-1:0] == bus.inbound_rd_ptr[PW-1:0]);
   assign out_avail = (out_rd_ptr[PW-1:0] != bus.outbound_wr_ptr[PW-1:0]);

   // Requests only exist in IDLE, so any grant is consumed in the cycle it is given.
   // The outbound request waits for the output register to empty.
   assign req[0] = (state == IDLE) && bus.inbound_valid && !in_full;
   assign req[1] = (state == IDLE) && out_avail && !out_valid;

   bidi_message_queue_rr_arb u_arb (
      .clk (clk),
      .rst (rst),
      .req (req),
      .gnt (gnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         in_wr_ptr  <= '0;
         out_rd_ptr <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         addr_q     <= '0;
         rd_en_q    <= 1'b0;
         wr_en_q    <= 1'b0;
         wdata_q    <= '0;
      end else begin
         if (out_valid && bus.outbound_ready) begin
            out_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (gnt[0]) begin
                  // Strobes are registered: they appear in the state that owns them.
                  wr_en_q <= 1'b1;
                  addr_q  <= {1'b0, in_wr_ptr[PW-1:0]};
                  wdata_q <= bus.inbound_data;
                  state   <= IN_WR;
               end else if (gnt[1]) begin
                  rd_en_q <= 1'b1;
                  addr_q  <= {1'b1, out_rd_ptr[PW-1:0]};
                  state   <= OUT_RD;
               end
            end
            IN_WR: begin
               wr_en_q   <= 1'b0;
               in_wr_ptr <= in_wr_ptr_nxt;
               state     <= IDLE;
            end
            OUT_RD: begin
               rd_en_q <= 1'b0;
               state   <= OUT_WAIT;
            end
            OUT_WAIT: begin
               // SRAM data for the OUT_RD strobe is present in this cycle.
               out_data   <= bus.sram_read_data;
               out_valid  <= 1'b1;
               out_rd_ptr <= out_rd_ptr_nxt;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.inbound_ready   = gnt[0];
   assign bus.outbound_data   = out_data;
   assign bus.outbound_valid  = out_valid;
   assign bus.inbound_wr_ptr  = in_wr_ptr;
   assign bus.outbound_rd_ptr = out_rd_ptr;
   assign bus.sram_addr       = addr_q;
   assign bus.sram_read_en    = rd_en_q;
   assign bus.sram_write_en   = wr_en_q;
   assign bus.sram_write_data = wdata_q;

   // Only the low pointer bits take part in comparisons.
   logic unused_ptr_bits;
   assign unused_ptr_bits = ^{bus.inbound_rd_ptr[31:PW], bus.outbound_wr_ptr[31:PW]};

`ifdef BIDI_MESSAGE_QUEUE_STREAM_IRQ_EN
   logic irq_q;
   // Set has priority over a same-cycle ack so a new word is never missed.
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_q <= 1'b0;
      end else if (state == IN_WR) begin
         irq_q <= 1'b1;
      end else if (bus.irq_ack) begin
         irq_q <= 1'b0;
      end
   end
   assign bus.irq = irq_q;
`else
   logic unused_irq_ack;
   assign unused_irq_ack = bus.irq_ack;
   assign bus.irq        = 1'b0;
`endif

endmodule
